// File: rtl/cwt_result_store.sv
// cwt_result_store: captures J scales x N samples of IFFT output into one half
// of a ping-pong external result memory, and drains each completed half to a
// valid/ready consumer with an optional power-of-two index stride.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   in_valid_i/in_re_i/in_im_i IFFT sample stream
//   busy_o                     write bank full; upstream must hold
//   wr_en_o/wr_addr_o/wr_re_o/wr_im_o   memory write port ({bank, j, k})
//   rd_en_o/rd_addr_o, mem_re_i/mem_im_i memory read port (data 1 cycle later)
//   decim_i                    readout stride 2^decim_i, sampled at bank start
//   rd_valid_o/rd_ready_i/rd_re_o/rd_im_o/rd_scale_o/rd_idx_o/rd_last_o
//                              output sample stream
//   frame_done_o, cwt_done_o   bank write / bank readout complete pulses
//   full_o, err_o              per-bank full flags, sticky overflow
module cwt_result_store #(
  parameter int N  = 1024,
  parameter int J  = 64,
  parameter int DW = 32,
  localparam int KW = $clog2(N),
  localparam int JW = (J > 1) ? $clog2(J) : 1,
  localparam int AW = $clog2(2 * N * J)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid_i,
  input  logic [DW-1:0] in_re_i,
  input  logic [DW-1:0] in_im_i,
  output logic          busy_o,
  output logic          wr_en_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [DW-1:0] wr_re_o,
  output logic [DW-1:0] wr_im_o,
  output logic          rd_en_o,
  output logic [AW-1:0] rd_addr_o,
  input  logic [DW-1:0] mem_re_i,
  input  logic [DW-1:0] mem_im_i,
  input  logic [1:0]    decim_i,
  input  logic          rd_ready_i,
  output logic          rd_valid_o,
  output logic [DW-1:0] rd_re_o,
  output logic [DW-1:0] rd_im_o,
  output logic [JW-1:0] rd_scale_o,
  output logic [KW-1:0] rd_idx_o,
  output logic          rd_last_o,
  output logic          frame_done_o,
  output logic          cwt_done_o,
  output logic [1:0]    full_o,
  output logic          err_o
);

  typedef enum logic [1:0] {R_IDLE, R_RUN, R_DRAIN} rstate_t;

  typedef struct packed {
    logic [JW-1:0] j;
    logic [KW-1:0] k;
    logic          last;
  } meta_t;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    meta_t         m;
  } ent_t;

  // Works for J == 1 too, where the j field is a single always-zero bit.
  function automatic logic [AW-1:0] mk_addr(input logic b, input logic [JW-1:0] j,
                                            input logic [KW-1:0] k);
    return (AW'(b) << (AW - 1)) | (AW'(j) << KW) | AW'(k);
  endfunction

  // ---------------- write side ----------------
  logic          wr_bank;
  logic [KW-1:0] wk;
  logic [JW-1:0] wj;
  logic [1:0]    full_q, full_set, full_clr;
  logic          acc, wr_fin;

  assign busy_o   = full_q[wr_bank];
  assign acc      = in_valid_i && !busy_o;
  assign wr_fin   = acc && (wk == KW'(N - 1)) && (wj == JW'(J - 1));
  assign full_set = wr_fin ? (2'b01 << wr_bank) : 2'b00;
  assign full_o   = full_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank      <= 1'b0;
      wk           <= '0;
      wj           <= '0;
      wr_en_o      <= 1'b0;
      wr_addr_o    <= '0;
      wr_re_o      <= '0;
      wr_im_o      <= '0;
      frame_done_o <= 1'b0;
      err_o        <= 1'b0;
      full_q       <= 2'b00;
    end else begin
      wr_en_o      <= acc;
      frame_done_o <= wr_fin;
      // Set and clear never hit the same bank, so both apply.
      full_q       <= (full_q & ~full_clr) | full_set;
      if (in_valid_i && busy_o) err_o <= 1'b1;
      if (acc) begin
        wr_addr_o <= mk_addr(wr_bank, wj, wk);
        wr_re_o   <= in_re_i;
        wr_im_o   <= in_im_i;
        if (wk == KW'(N - 1)) begin
          wk <= '0;
          if (wj == JW'(J - 1)) begin
            wj      <= '0;
            wr_bank <= ~wr_bank;
          end else begin
            wj <= wj + 1'b1;
          end
        end else begin
          wk <= wk + 1'b1;
        end
      end
    end
  end

  // ---------------- read side ----------------
  rstate_t       state, state_d;
  logic          rd_bank;
  logic [1:0]    dec_q;
  logic [KW-1:0] rk;
  logic [JW-1:0] rj;
  logic [KW:0]   stride, k_lim;
  logic          rk_wrap, rj_wrap, issue, last_issue, pop, done;
  // vld_pipe[0]: read strobe on the memory port; vld_pipe[1]: read data present
  logic [1:0]    vld_pipe;
  meta_t         meta_q [2];
  ent_t          fifo [4];
  logic [1:0]    wp, rp;
  logic [2:0]    cnt;
  ent_t          head;

  assign stride  = (KW + 1)'(1) << dec_q;
  assign k_lim   = (KW + 1)'(N) - stride;
  assign rk_wrap = ({1'b0, rk} == k_lim);
  assign rj_wrap = (rj == JW'(J - 1));

  // Reads in flight are reserved against FIFO space so the memory never
  // returns data with nowhere to go.
  assign issue      = (state == R_RUN) &&
                      (({1'b0, cnt} + 4'(vld_pipe[0]) + 4'(vld_pipe[1])) < 4'd4);
  assign last_issue = issue && rk_wrap && rj_wrap;

  assign head       = fifo[rp];
  assign rd_valid_o = (cnt != 3'd0);
  assign pop        = rd_valid_o && rd_ready_i;
  assign done       = (state == R_DRAIN) && pop && head.m.last && (cnt == 3'd1);
  assign full_clr   = done ? (2'b01 << rd_bank) : 2'b00;

  assign rd_en_o    = vld_pipe[0];
  assign rd_re_o    = head.re;
  assign rd_im_o    = head.im;
  assign rd_scale_o = head.m.j;
  assign rd_idx_o   = head.m.k;
  assign rd_last_o  = rd_valid_o && head.m.last;

  always_comb begin
    state_d = state;
    case (state)
      R_IDLE:  if (full_q[rd_bank]) state_d = R_RUN;
      R_RUN:   if (last_issue)      state_d = R_DRAIN;
      R_DRAIN: if (done)            state_d = R_IDLE;
      default:                      state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= R_IDLE;
      rd_bank    <= 1'b0;
      dec_q      <= 2'd0;
      rk         <= '0;
      rj         <= '0;
      vld_pipe   <= 2'b00;
      rd_addr_o  <= '0;
      meta_q[0]  <= '0;
      meta_q[1]  <= '0;
      wp         <= 2'd0;
      rp         <= 2'd0;
      cnt        <= 3'd0;
      cwt_done_o <= 1'b0;
      for (int i = 0; i < 4; i++) fifo[i] <= '0;
    end else begin
      state      <= state_d;
      cwt_done_o <= done;
      vld_pipe   <= {vld_pipe[0], issue};
      if (state == R_IDLE && full_q[rd_bank]) begin
        dec_q <= decim_i;
        rk    <= '0;
        rj    <= '0;
      end
      if (issue) begin
        rd_addr_o <= mk_addr(rd_bank, rj, rk);
        meta_q[0] <= '{j: rj, k: rk, last: rk_wrap && rj_wrap};
        if (rk_wrap) begin
          rk <= '0;
          rj <= rj_wrap ? '0 : rj + 1'b1;
        end else begin
          rk <= rk + stride[KW-1:0];
        end
      end
      if (vld_pipe[0]) meta_q[1] <= meta_q[0];
      if (vld_pipe[1]) begin
        fifo[wp] <= '{re: mem_re_i, im: mem_im_i, m: meta_q[1]};
        wp       <= wp + 2'd1;
      end
      if (pop) rp <= rp + 2'd1;
      cnt <= cnt + 3'(vld_pipe[1]) - 3'(pop);
      if (done) rd_bank <= ~rd_bank;
    end
  end

endmodule
